// File: rtl/crc_byte_sequencer_if.sv
// Byte stream channel into crc_byte_sequencer.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high. The source holds in_data/in_last stable while
// in_valid is high and may not retract in_valid before the transfer. The
// sink may raise or drop in_ready in any cycle. in_last marks the
// transferred byte as the final byte of the message.
//
// Signals:
//   in_valid  source -> sink  byte available
//   in_ready  sink -> source  sink accepts a byte this cycle
//   in_data   source -> sink  message byte
//   in_last   source -> sink  byte is the final one of the message
interface crc_byte_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/crc_byte_sequencer.sv
// Byte-level front end for the bit-serial lfsrN CRC stage.
//
// Accepts a CRC configuration on start and a byte stream on in_if, then
// drives the LFSR's load/shift/data controls one bit per cycle. At the end
// of the message the LFSR register is masked to N bits, optionally
// reflected, XORed with the final value and presented on crc_out with a
// one-cycle done pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a message (honoured in IDLE/DONE)
//   cfg_*             width-1, init, xorout, refin, refout; captured at start
//   in_if             byte stream (slave side)
//   flush             finish with no further bytes (honoured in WAIT)
//   lfsr_load/shift/data, lfsr_bitwidth, lfsr_init   LFSR controls
//   lfsr_value        current LFSR register
//   busy, done, crc_out   status and result
//   state_dbg         current FSM state encoding
module crc_byte_sequencer #(
    parameter int MAX_BITS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [5:0]          cfg_width_m1,
    input  logic [MAX_BITS-1:0] cfg_init,
    input  logic [MAX_BITS-1:0] cfg_xorout,
    input  logic                cfg_refin,
    input  logic                cfg_refout,
    crc_byte_sequencer_if.slave in_if,
    input  logic                flush,
    output logic                lfsr_load,
    output logic                lfsr_shift,
    output logic                lfsr_data,
    output logic [5:0]          lfsr_bitwidth,
    output logic [MAX_BITS-1:0] lfsr_init,
    input  logic [MAX_BITS-1:0] lfsr_value,
    output logic                busy,
    output logic                done,
    output logic [MAX_BITS-1:0] crc_out,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state, state_next;
    logic [5:0]          width_q;
    logic [MAX_BITS-1:0] init_q;
    logic [MAX_BITS-1:0] xorout_q;
    logic                refin_q;
    logic                refout_q;
    logic [7:0]          byte_q;
    logic                last_q;
    logic [2:0]          bit_cnt;

    logic [MAX_BITS-1:0] mask;
    logic [MAX_BITS-1:0] masked;
    logic [MAX_BITS-1:0] reflected;
    logic [MAX_BITS-1:0] crc_next;

    assign lfsr_bitwidth = width_q;
    assign lfsr_init     = init_q;
    assign state_dbg     = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-state outputs
    always_comb begin
        state_next     = state;
        in_if.in_ready = 1'b0;
        lfsr_load      = 1'b0;
        lfsr_shift     = 1'b0;
        lfsr_data      = 1'b0;
        busy           = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                lfsr_load  = 1'b1;
                busy       = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                in_if.in_ready = 1'b1;
                busy           = 1'b1;
                // A presented byte wins over flush in the same cycle.
                if (in_if.in_valid) begin
                    state_next = S_SHIFT;
                end else if (flush) begin
                    state_next = S_FINAL;
                end
            end
            S_SHIFT: begin
                lfsr_shift = 1'b1;
                busy       = 1'b1;
                // refin feeds the byte LSB first, otherwise MSB first.
                lfsr_data  = refin_q ? byte_q[bit_cnt] : byte_q[3'd7 - bit_cnt];
                if (bit_cnt == 3'd7) begin
                    state_next = last_q ? S_FINAL : S_WAIT;
                end
            end
            S_FINAL: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Result formation: mask to N bits, optional reflection over N bits,
    // final XOR, and re-mask so bits above N read zero.
    always_comb begin
        logic [5:0] j;
        j         = '0;
        mask      = {MAX_BITS{1'b1}} >> (MAX_BITS - 1 - int'(width_q));
        masked    = lfsr_value & mask;
        reflected = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i <= int'(width_q)) begin
                j            = width_q - 6'(i);
                reflected[i] = masked[j];
            end
        end
        crc_next = ((refout_q ? reflected : masked) ^ xorout_q) & mask;
    end

    // Configuration, byte holding register, bit counter and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q  <= '0;
            init_q   <= '0;
            xorout_q <= '0;
            refin_q  <= 1'b0;
            refout_q <= 1'b0;
            byte_q   <= '0;
            last_q   <= 1'b0;
            bit_cnt  <= '0;
            crc_out  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        width_q  <= cfg_width_m1;
                        init_q   <= cfg_init;
                        xorout_q <= cfg_xorout;
                        refin_q  <= cfg_refin;
                        refout_q <= cfg_refout;
                        crc_out  <= '0;
                    end
                end
                S_WAIT: begin
                    if (in_if.in_valid) begin
                        byte_q  <= in_if.in_data;
                        last_q  <= in_if.in_last;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
                S_FINAL: begin
                    // FINAL lasts one cycle, so done is high only for the
                    // first DONE cycle.
                    crc_out <= crc_next;
                    done    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_byte_sequencer.sv
module tb_crc_byte_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  cfg_width_m1;
  logic [63:0] cfg_init;
  logic [63:0] cfg_xorout;
  logic        cfg_refin;
  logic        cfg_refout;
  logic        flush;
  logic        lfsr_load;
  logic        lfsr_shift;
  logic        lfsr_data;
  logic [5:0]  lfsr_bitwidth;
  logic [63:0] lfsr_init;
  logic [63:0] lfsr_value;
  logic        busy;
  logic        done;
  logic [63:0] crc_out;
  logic [2:0]  state_dbg;

  crc_byte_sequencer_if bus();

  crc_byte_sequencer #(.MAX_BITS(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_width_m1  (cfg_width_m1),
    .cfg_init      (cfg_init),
    .cfg_xorout    (cfg_xorout),
    .cfg_refin     (cfg_refin),
    .cfg_refout    (cfg_refout),
    .in_if         (bus),
    .flush         (flush),
    .lfsr_load     (lfsr_load),
    .lfsr_shift    (lfsr_shift),
    .lfsr_data     (lfsr_data),
    .lfsr_bitwidth (lfsr_bitwidth),
    .lfsr_init     (lfsr_init),
    .lfsr_value    (lfsr_value),
    .busy          (busy),
    .done          (done),
    .crc_out       (crc_out),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  // ---------------- counters / checker ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mask_of(input int w_m1);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i <= w_m1; i++) m[i] = 1'b1;
    return m;
  endfunction

  // ---------------- LFSR stage stand-in ----------------
  // MSB-first Galois register of N bits; bits above N are left untouched
  // so the sequencer's masking is exercised.
  logic [63:0] poly;
  initial lfsr_value = '0;
  always @(posedge clk) begin
    if (lfsr_load)
      lfsr_value <= lfsr_init;
    else if (lfsr_shift)
      lfsr_value <= (lfsr_value << 1) ^
                    ((lfsr_value[lfsr_bitwidth] ^ lfsr_data) ? (poly & mask_of(int'(lfsr_bitwidth))) : 64'd0);
  end

  // ---------------- reference CRC ----------------
  logic [7:0] msg_q[$];

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [63:0] crc_ref(input int n, input logic [63:0] init, input logic [63:0] xo,
                                          input logic [63:0] p, input bit ri, input bit ro);
    logic [63:0] m, r, pm, rr;
    logic [7:0]  b;
    bit          fb;
    m  = mask_of(n - 1);
    r  = init & m;
    pm = p & m;
    foreach (msg_q[j]) begin
      b = ri ? rev8(msg_q[j]) : msg_q[j];
      if (n >= 8) begin
        r = r ^ ({56'd0, b} << (n - 8));
        for (int s = 0; s < 8; s++) r = (r[n-1] ? ((r << 1) ^ pm) : (r << 1)) & m;
      end else begin
        for (int i = 7; i >= 0; i--) begin
          fb = r[n-1] ^ b[i];
          r  = ((r << 1) ^ (fb ? pm : 64'd0)) & m;
        end
      end
    end
    if (ro) begin
      rr = '0;
      for (int i = 0; i < n; i++) rr[i] = r[n-1-i];
      r = rr;
    end
    return (r ^ xo) & m;
  endfunction

  // ---------------- cycle-level model and compare ----------------
  logic [63:0] exp_q[$];
  int          cyc = 0;
  int          load_cyc, shift_from, wait_from, busy_from, busy_to, done_cyc, final_cyc;
  logic [63:0] exp_crc;
  logic [5:0]  m_w;
  logic [63:0] m_init, m_xo;
  bit          m_ri, m_ro;
  logic [7:0]  cur_byte;
  bit          e_load, e_shift, e_ready, e_busy, e_done;
  int          k;

  task automatic model_reset();
    load_cyc = -1; shift_from = -1; wait_from = -1; busy_from = -1;
    busy_to = -1; done_cyc = -1; final_cyc = -1;
    exp_crc = '0; m_w = '0; m_init = '0; m_xo = '0; m_ri = 0; m_ro = 0;
    cur_byte = '0;
    exp_q.delete();
    msg_q.delete();
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc++;
      e_load  = (cyc == load_cyc);
      e_shift = (shift_from >= 0) && (cyc >= shift_from) && (cyc < shift_from + 8);
      e_ready = (wait_from >= 0) && (cyc >= wait_from);
      e_busy  = (busy_from >= 0) && (cyc >= busy_from) && (cyc < busy_to);
      e_done  = (cyc == done_cyc);
      check("lfsr_load", lfsr_load, e_load);
      check("lfsr_shift", lfsr_shift, e_shift);
      check("load_shift_excl", lfsr_load & lfsr_shift, 0);
      check("in_ready", bus.in_ready, e_ready);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("crc_out", crc_out, exp_crc);
      check("lfsr_bitwidth", lfsr_bitwidth, m_w);
      check("lfsr_init", lfsr_init, m_init);
      if (e_shift) begin
        k = cyc - shift_from;
        check("lfsr_data", lfsr_data, m_ri ? cur_byte[k] : cur_byte[7-k]);
      end
      // events taking effect on the coming edge
      if (!e_busy && start) begin
        m_w = cfg_width_m1; m_init = cfg_init; m_xo = cfg_xorout;
        m_ri = cfg_refin; m_ro = cfg_refout;
        load_cyc = cyc + 1; wait_from = cyc + 2; busy_from = cyc + 1;
        busy_to = 1 << 30; exp_crc = '0;
        msg_q.delete();
      end else if (e_ready) begin
        if (bus.in_valid) begin
          cur_byte = bus.in_data;
          msg_q.push_back(bus.in_data);
          shift_from = cyc + 1;
          if (bus.in_last) begin
            wait_from = -1; final_cyc = cyc + 9; done_cyc = cyc + 10; busy_to = cyc + 10;
            exp_q.push_back(crc_ref(int'(m_w) + 1, m_init, m_xo, poly, m_ri, m_ro));
          end else begin
            wait_from = cyc + 9;
          end
        end else if (flush) begin
          wait_from = -1; final_cyc = cyc + 1; done_cyc = cyc + 2; busy_to = cyc + 2;
          exp_q.push_back(crc_ref(int'(m_w) + 1, m_init, m_xo, poly, m_ri, m_ro));
        end
      end
      if (cyc == final_cyc && exp_q.size() > 0) exp_crc = exp_q.pop_front();
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] tx_q[$];
  int         acc_log[$];

  task automatic do_start(input int w_m1, input logic [63:0] init, input logic [63:0] xo,
                          input logic [63:0] p, input bit ri, input bit ro);
    @(posedge clk); #1;
    cfg_width_m1 = 6'(w_m1); cfg_init = init; cfg_xorout = xo;
    cfg_refin = ri; cfg_refout = ro; poly = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, input bit hold, output int acc);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_data = b; bus.in_last = l;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    acc = tcyc;
    acc_log.push_back(acc);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic do_flush(output int acc);
    int n;
    n = 0;
    flush = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("flush_timeout", bus.in_ready, 1);
    @(posedge clk);
    acc = tcyc;
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 400);
    if (!done) check("done_timeout", done, 1);
  endtask

  task automatic run_msg(input int w_m1, input logic [63:0] init, input logic [63:0] xo,
                         input logic [63:0] p, input bit ri, input bit ro,
                         input bit use_flush, input bit hold, input bit gaps, output int lat);
    int acc;
    do_start(w_m1, init, xo, p, ri, ro);
    acc_log.delete();
    for (int j = 0; j < tx_q.size(); j++) begin
      send_byte(tx_q[j], (!use_flush && j == tx_q.size() - 1), hold, acc);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    if (use_flush || tx_q.size() == 0) do_flush(acc);
    wait_done(lat);
  endtask

  task automatic set_check_msg();
    tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"}, lfsr_load, 0);
    check({tag, "_shift"}, lfsr_shift, 0);
    check({tag, "_data"}, lfsr_data, 0);
    check({tag, "_ready"}, bus.in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_crc"}, crc_out, 0);
    check({tag, "_bitwidth"}, lfsr_bitwidth, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, acc, w, len;
    bit ri, ro, uf, hold;
    logic [63:0] init, xo, p;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    cfg_width_m1 = '0; cfg_init = '0; cfg_xorout = '0; cfg_refin = 1'b0; cfg_refout = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    poly = '0;
    #3;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // CRC-8
    set_check_msg();
    run_msg(7, 64'h0, 64'h0, 64'h07, 0, 0, 0, 0, 0, lat);
    check("crc8_value", crc_out, 64'hF4);
    check("crc8_done_latency", lat, 10);

    // CRC-16/CCITT-FALSE
    set_check_msg();
    run_msg(15, 64'hFFFF, 64'h0, 64'h1021, 0, 0, 0, 0, 1, lat);
    check("crc16_value", crc_out, 64'h29B1);

    // CRC-32 with a start pulse during SHIFT that must be ignored
    set_check_msg();
    do_start(31, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h04C11DB7, 1, 1);
    for (int j = 0; j < 9; j++) begin
      send_byte(tx_q[j], (j == 8), 0, acc);
      if (j == 1) begin
        @(posedge clk); #1;
        start = 1'b1; cfg_init = 64'h0; cfg_refin = 1'b0; cfg_width_m1 = 6'd7;
        @(posedge clk); #1;
        start = 1'b0; cfg_init = 64'hFFFFFFFF; cfg_refin = 1'b1; cfg_width_m1 = 6'd31;
      end
    end
    wait_done(lat);
    check("crc32_value", crc_out, 64'h00000000CBF43926);
    check("crc32_done_latency", lat, 10);

    // zero-length CRC-32
    tx_q.delete();
    run_msg(31, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h04C11DB7, 1, 1, 1, 0, 0, lat);
    check("crc32_empty_value", crc_out, 64'h0);
    check("flush_done_latency", lat, 2);

    // backpressure: in_valid held high throughout
    set_check_msg();
    run_msg(7, 64'h0, 64'h0, 64'h07, 0, 0, 0, 1, 0, lat);
    check("crc8_stream_value", crc_out, 64'hF4);
    for (int j = 1; j < acc_log.size(); j++)
      check("accept_spacing", acc_log[j] - acc_log[j-1], 9);

    // reset during the 5th shift of byte 3
    set_check_msg();
    do_start(7, 64'h0, 64'h0, 64'h07, 0, 0);
    for (int j = 0; j < 3; j++) send_byte(tx_q[j], 0, 0, acc);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_check_msg();
    run_msg(7, 64'h0, 64'h0, 64'h07, 0, 0, 0, 0, 0, lat);
    check("crc8_after_reset", crc_out, 64'hF4);

    // randomized messages
    for (int t = 0; t < 30; t++) begin
      w    = $urandom_range(0, 63);
      init = {$urandom, $urandom};
      xo   = {$urandom, $urandom};
      p    = {$urandom, $urandom} | 64'd1;
      ri   = 1'($urandom_range(0, 1));
      ro   = 1'($urandom_range(0, 1));
      len  = $urandom_range(0, 5);
      uf   = (len == 0) || ($urandom_range(0, 3) == 0);
      hold = 1'($urandom_range(0, 1));
      tx_q.delete();
      for (int j = 0; j < len; j++) tx_q.push_back(8'($urandom));
      // with valid held between bytes, an early flush must lose to the bytes
      if (uf && hold && len > 0) flush = 1'b1;
      run_msg(w, init, xo, p, ri, ro, uf, hold, !hold, lat);
      flush = 1'b0;
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc_byte_sequencer.md
# crc_byte_sequencer

Byte-level front end for the codebase's bit-serial `lfsrN` CRC stage. It accepts a configuration and a stream of bytes over a valid/ready handshake, and drives the LFSR's load/shift/data controls one bit per cycle. When the message ends it applies output reflection and the final XOR, then presents the finished CRC with a one-cycle `done` pulse. The polynomial taps go from the top level straight to the LFSR and do not pass through this block.

## Interface
- `MAX_BITS`, 64, LFSR register width; must match the LFSR stage.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new message; honoured only in IDLE or DONE.
- `cfg_width_m1`  in  6  CRC width N minus 1 (e.g. 31 for CRC-32); captured at `start`.
- `cfg_init`  in  MAX_BITS  initial register value; captured at `start`.
- `cfg_xorout`  in  MAX_BITS  final XOR value; captured at `start`.
- `cfg_refin`  in  1  1 = bytes fed LSB first; captured at `start`.
- `cfg_refout`  in  1  1 = reflect result over N bits; captured at `start`.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  block can accept a byte.
- `in_data`  in  8  message byte.
- `in_last`  in  1  qualifies the accepted byte as final.
- `flush`  in  1  finalize with no further bytes (zero-length or already-fed message); honoured only in WAIT.
- `lfsr_load`, `lfsr_shift`, `lfsr_data`  out  1 each  LFSR command and data bit.
- `lfsr_bitwidth`  out  6  equals captured `cfg_width_m1`.
- `lfsr_init`  out  MAX_BITS  equals captured `cfg_init`.
- `lfsr_value`  in  MAX_BITS  current LFSR register.
- `busy`  out  1  high in LOAD, WAIT, SHIFT, FINAL.
- `done`  out  1  one-cycle pulse when `crc_out` becomes valid.
- `crc_out`  out  MAX_BITS  final CRC, zero-extended above N; held until the next `start` or reset.

## Operation
- States: IDLE, LOAD, WAIT, SHIFT, FINAL, DONE.
  - IDLE/DONE → LOAD on `start`. The cfg registers capture on the same edge, and `crc_out` clears on the same edge.
  - LOAD: `lfsr_load` = 1 for one cycle → WAIT.
  - WAIT: `in_ready` = 1.
    - On `in_valid`: capture the byte and `in_last`, clear the bit counter, → SHIFT.
    - Else if `flush`: → FINAL.
    - `in_valid` has priority over `flush` in the same cycle.
  - SHIFT: `lfsr_shift` = 1 for exactly 8 cycles. The bit counter counts 0..7.
    - `lfsr_data` = byte[7−k] when `cfg_refin` = 0, byte[k] when `cfg_refin` = 1, where k is the counter value.
    - After k = 7: → FINAL if the captured last flag is set, else → WAIT.
  - FINAL: one cycle.
    - r = `lfsr_value` masked to bits [N−1:0].
    - If `cfg_refout`, r[i] ← r[N−1−i] for i < N.
    - `crc_out` ← (r ^ `cfg_xorout`) masked to N bits. → DONE.
  - DONE: `done` = 1 for this cycle only. The state stays DONE, with `done` = 0, until `start`.
- `lfsr_load` and `lfsr_shift` are never high together. Both are 0 outside LOAD/SHIFT.
- `start` outside IDLE/DONE is ignored; no restart while busy.
- `in_ready` is 0 in every state except WAIT. A byte presented in other states is neither accepted nor dropped; it waits.
- `flush` outside WAIT is ignored.
- Zero-length message (`start`, then `flush`): result is the reflected/XORed `cfg_init`.
- N = 1..64. When N = 64 the mask covers all bits.

## Timing
- Reset (async assert, synchronous release): state IDLE; `in_ready`, `lfsr_load`, `lfsr_shift`, `lfsr_data`, `busy`, `done` = 0; `crc_out`, cfg registers = 0.
  - Reset mid-message abandons the message without producing `done`.
  - The LFSR stage resets separately on its own reset.
- `start` at edge t: LOAD during cycle t+1, WAIT from t+2.
- Byte accepted at edge t: `lfsr_shift` high during cycles t+1..t+8.
  - Next `in_ready` at t+9, giving a throughput of one byte per 9 cycles.
- Last byte accepted at edge t: FINAL during t+9, `done` = 1 and `crc_out` valid during t+10.
- `flush` at edge t: FINAL during t+1, `done` during t+2.
- `lfsr_data` is combinational from registered byte and counter. The LFSR samples it on the same edge as `lfsr_shift`.

## Test plan
- CRC-8 (N = 8, taps 0x07, init 0, no reflect, xorout 0) on ASCII "123456789" with `in_last` on '9' → `crc_out` = 0xF4. `done` exactly 10 cycles after the last accept.
- CRC-16/CCITT-FALSE (N = 16, taps 0x1021, init 0xFFFF) on "123456789" → 0x29B1.
- CRC-32 (taps 0x04C11DB7, init and xorout 0xFFFFFFFF, refin = refout = 1) on "123456789" → 0xCBF43926. Bits above 31 of `crc_out` read 0.
- Zero-length CRC-32: `start`, then `flush` → 0x00000000. Assert `start` during SHIFT → no effect, result unchanged.
- Backpressure: `in_valid` held continuously → `in_ready` high 1 cycle in every 9. `lfsr_load` and `lfsr_shift` are never both high. Same CRC as the unstalled run.
- Drop `rst_n` during the 5th shift of byte 3 → all outputs 0 immediately. A new CRC-8 run afterwards → 0xF4.
